prog_loader_ctrl: RTL and testbench



---
 rtl/prog_loader_pkg.sv | 27 ++
 rtl/prog_loader_ctrl.sv | 160 ++++++++++++++++
 tb/tb_prog_loader_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the PicoBlaze program-memory loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_H,
        LEN_L,
        B0,
        B1,
        B2,
        WRITE,
        CHK
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h5A;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHK  = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    // A frame must carry at least one word and no more than the RAM holds.
    function automatic logic len_ok(input logic [10:0] len, input int addr_w);
        return (len != 11'd0) && ({21'd0, len} <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/prog_loader_ctrl.sv
// Framed byte-stream loader for the PicoBlaze 1024x18 program RAM; holds the
// processor in reset from SYNC until the frame checksum passes.
//
// state | meaning
// IDLE  | waiting for SYNC, other bytes discarded
// LEN_H | expecting length high byte
// LEN_L | expecting length low byte, range check
// B0    | expecting word bits [17:16]
// B1    | expecting word bits [15:8]
// B2    | expecting word bits [7:0]
// WRITE | one-cycle RAM write strobe, rx_ready low
// CHK   | expecting checksum byte
module prog_loader_ctrl
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [17:0]       ram_wdata,
    output logic              proc_reset,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

    state_t            state;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [7:0]        chk_sum;
    logic [2:0]        len_hi;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_idx;
    logic [1:0]        word_hi;
    logic [7:0]        word_mid;

    logic              accept;
    logic              tmo_hit;
    logic [10:0]       len_v;
    logic [7:0]        chk_fin;

    // Terminal count forces rx_ready low so no byte is lost on the abort cycle.
    assign tmo_hit  = (state != IDLE) && (tmo_cnt == '0);
    assign rx_ready = (state != WRITE) && !tmo_hit;
    assign accept   = rx_valid && rx_ready;
    assign busy     = (state != IDLE);
    assign len_v    = {len_hi, rx_data};
    assign chk_fin  = chk_sum + rx_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tmo_cnt    <= TMO_LOAD;
            chk_sum    <= 8'd0;
            len_hi     <= 3'd0;
            idx        <= '0;
            last_idx   <= '0;
            word_hi    <= 2'd0;
            word_mid   <= 8'd0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= 18'd0;
            proc_reset <= 1'b0;
            done       <= 1'b0;
            err        <= ERR_NONE;
        end else begin
            done   <= 1'b0;
            ram_we <= 1'b0;

            if (tmo_hit) begin
                err   <= ERR_TMO;
                state <= IDLE;
            end else begin
                if (accept) begin
                    tmo_cnt <= TMO_LOAD;
                end else if (state != IDLE) begin
                    tmo_cnt <= tmo_cnt - TMO_W'(1);
                end

                if (accept && state != IDLE) begin
                    chk_sum <= chk_fin;
                end

                case (state)
                    IDLE: begin
                        if (accept && rx_data == SYNC_BYTE) begin
                            proc_reset <= 1'b1;
                            err        <= ERR_NONE;
                            chk_sum    <= 8'd0;
                            idx        <= '0;
                            state      <= LEN_H;
                        end
                    end
                    LEN_H: begin
                        if (accept) begin
                            len_hi <= rx_data[2:0];
                            state  <= LEN_L;
                        end
                    end
                    LEN_L: begin
                        if (accept) begin
                            if (!len_ok(len_v, ADDR_W)) begin
                                err   <= ERR_LEN;
                                state <= IDLE;
                            end else begin
                                last_idx <= ADDR_W'(len_v - 11'd1);
                                state    <= B0;
                            end
                        end
                    end
                    B0: begin
                        if (accept) begin
                            word_hi <= rx_data[1:0];
                            state   <= B1;
                        end
                    end
                    B1: begin
                        if (accept) begin
                            word_mid <= rx_data;
                            state    <= B2;
                        end
                    end
                    B2: begin
                        if (accept) begin
                            ram_we    <= 1'b1;
                            ram_addr  <= idx;
                            ram_wdata <= {word_hi, word_mid, rx_data};
                            state     <= WRITE;
                        end
                    end
                    WRITE: begin
                        idx   <= idx + ADDR_W'(1);
                        state <= (idx == last_idx) ? CHK : B0;
                    end
                    CHK: begin
                        if (accept) begin
                            if (chk_fin == 8'h00) begin
                                done       <= 1'b1;
                                proc_reset <= 1'b0;
                            end else begin
                                err <= ERR_CHK;
                            end
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Scoreboard bench for prog_loader_ctrl: frames built from the byte-format
// rules, expected writes/done pulses queued, monitor compares on each strobe.
module tb_prog_loader_ctrl;
    import prog_loader_pkg::*;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [17:0]       ram_wdata;
    logic              proc_reset;
    logic              busy;
    logic              done;
    logic [1:0]        err;

    always #5 clk = ~clk;

    prog_loader_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .proc_reset (proc_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int tests = 0;
    int fails = 0;

    int          exp_addr[$];
    int          exp_data[$];
    int          exp_done = 0;
    logic [17:0] words_q[$];

    int   cyc     = 0;
    int   last_we = -1;
    logic win     = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: compares every write strobe and done pulse against the queues.
    always @(negedge clk) begin
        int a;
        int d;
        cyc++;
        if (ram_we) begin
            check("write_expected", int'(exp_addr.size() > 0), 1);
            if (exp_addr.size() > 0) begin
                a = exp_addr.pop_front();
                d = exp_data.pop_front();
                check("ram_addr", int'(ram_addr), a);
                check("ram_wdata", int'(ram_wdata), d);
            end
            if (win) begin
                if (last_we >= 0) check("we_spacing", cyc - last_we, 4);
                last_we = cyc;
            end
        end
        if (win) check("rx_ready_vs_write", int'(rx_ready), int'(!ram_we));
        if (done) begin
            check("done_expected", int'(exp_done > 0), 1);
            if (exp_done > 0) begin
                exp_done--;
                check("proc_reset_at_done", int'(proc_reset), 0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("rx_ready_wait", int'(rx_ready), 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Builds a frame from words_q; cut>0 sends only the first cut bytes.
    task automatic run_frame(input int len_field, input logic [4:0] hi_noise,
                             input int chk_delta, input int gap_max, input int cut);
        logic [7:0] bytes[$];
        logic [7:0] hi, lo, chk, b0, b1, b2;
        int sum;
        int n_send;
        int full_words;
        hi  = {hi_noise, 3'(len_field >> 8)};
        lo  = 8'(len_field);
        sum = int'(hi) + int'(lo);
        bytes.push_back(SYNC_BYTE);
        bytes.push_back(hi);
        bytes.push_back(lo);
        for (int i = 0; i < words_q.size(); i++) begin
            b0 = {6'($urandom), words_q[i][17:16]};
            b1 = words_q[i][15:8];
            b2 = words_q[i][7:0];
            bytes.push_back(b0);
            bytes.push_back(b1);
            bytes.push_back(b2);
            sum += int'(b0) + int'(b1) + int'(b2);
        end
        chk = 8'((256 - (sum % 256)) % 256);
        chk = chk + 8'(chk_delta);
        bytes.push_back(chk);

        n_send     = (cut > 0) ? cut : bytes.size();
        full_words = (cut > 0) ? (cut - 3) / 3 : words_q.size();
        for (int i = 0; i < full_words; i++) begin
            exp_addr.push_back(i);
            exp_data.push_back(int'(words_q[i]));
        end
        if (cut == 0 && chk_delta == 0) exp_done++;

        send_byte(bytes[0]);
        check("proc_reset_after_sync", int'(proc_reset), 1);
        check("busy_after_sync", int'(busy), 1);
        check("err_cleared_at_sync", int'(err), 0);
        for (int i = 1; i < n_send; i++) begin
            if (gap_max > 0) idle($urandom_range(0, gap_max));
            send_byte(bytes[i]);
        end
        if (cut == 0) begin
            check("err_after_frame", int'(err), (chk_delta == 0) ? 0 : 1);
            check("proc_reset_after_frame", int'(proc_reset), (chk_delta == 0) ? 0 : 1);
            check("busy_after_frame", int'(busy), 0);
        end
    endtask

    task automatic len_error(input logic [7:0] hi, input logic [7:0] lo);
        send_byte(SYNC_BYTE);
        send_byte(hi);
        send_byte(lo);
        check("err_len", int'(err), 2);
        check("busy_len", int'(busy), 0);
        check("proc_reset_len", int'(proc_reset), 1);
        check("rx_ready_len", int'(rx_ready), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, int'(rx_ready), 1);
        check({tag, "_ram_we"}, int'(ram_we), 0);
        check({tag, "_ram_addr"}, int'(ram_addr), 0);
        check({tag, "_ram_wdata"}, int'(ram_wdata), 0);
        check({tag, "_proc_reset"}, int'(proc_reset), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    initial begin
        int len;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;
        @(negedge clk);

        words_q = '{18'h3FFFF, 18'h00123};
        run_frame(2, 5'd0, 0, 0, 0);
        idle(3);
        run_frame(2, 5'd0, 1, 0, 0);
        idle(3);

        len_error(8'h00, 8'h00);
        idle(2);
        len_error(8'hFC, 8'h01);
        idle(2);

        // Stall after b1 of word 0: abort exactly TIMEOUT cycles later.
        send_byte(SYNC_BYTE);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h34);
        idle(TIMEOUT - 1);
        check("busy_before_timeout", int'(busy), 1);
        idle(1);
        check("err_timeout", int'(err), 3);
        check("busy_timeout", int'(busy), 0);
        check("proc_reset_timeout", int'(proc_reset), 1);
        idle(2);
        words_q = '{18'h2ABCD};
        run_frame(1, 5'd3, 0, 0, 0);
        idle(2);

        // Full-depth frame at one byte per cycle, after garbage.
        win     = 1'b1;
        last_we = -1;
        send_byte(8'h00);
        send_byte(8'hFF);
        check("busy_after_garbage", int'(busy), 0);
        words_q.delete();
        for (int i = 0; i < 1024; i++) words_q.push_back(18'($urandom));
        run_frame(1024, 5'd0, 0, 0, 0);
        win = 1'b0;
        idle(2);

        repeat (20) begin
            len = $urandom_range(1, 6);
            words_q.delete();
            for (int i = 0; i < len; i++) words_q.push_back(18'($urandom));
            run_frame(len, 5'($urandom), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 255) : 0,
                      3, 0);
            idle($urandom_range(0, 3));
        end

        // Reset mid-frame, after b0 of word 5.
        words_q.delete();
        for (int i = 0; i < 8; i++) words_q.push_back(18'($urandom));
        run_frame(8, 5'd0, 0, 0, 3 + 5 * 3 + 1);
        #2 reset = 1'b1;
        #1 check_reset_values("midreset");
        @(negedge clk);
        reset = 1'b0;
        idle(10);
        check("proc_reset_after_midreset", int'(proc_reset), 0);
        words_q = '{18'h01234, 18'h3C3C3};
        run_frame(2, 5'd0, 0, 1, 0);

        idle(5);
        check("pending_writes", exp_addr.size(), 0);
        check("pending_done", exp_done, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
